regfile_writeback: RTL
======================

# regfile_writeback

Write-side front end for the 32x32 register file. Accepts results from the single-cycle ALU and from the memory/load unit (valid/ready handshake, buffered in a small FIFO), arbitrates them onto the register file's single write port, and drops writes to r0. Also keeps a 32-bit pending-write scoreboard that the issue/hazard logic sets on dispatch and this block clears when the write lands.

## Interface
Parameters:
- DEPTH, 2, load-result FIFO depth (power of two, ≥2)
- STARVE_LIMIT, 4, max consecutive cycles a non-empty FIFO head may lose arbitration (1..15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle (no ready; must be 0 while alu_hold=1)
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  FIFO can accept (= !full, from registered count)
- mem_rd  in  5  load destination register
- mem_data  in  32  load result
- claim_en  in  1  issue stage marks claim_rd pending
- claim_rd  in  5  register being claimed
- pending  out  32  bit i = write to ri outstanding; bit 0 always 0
- alu_hold  out  1  ALU must not present a result this cycle
- write_reg  out  5  register-file write address (registered)
- wb_data  out  32  register-file write data (registered)
- ranwi  out  1  register-file write enable (registered)

## Operation
- Reset (async, any time incl. mid-transfer): ranwi=0, write_reg=0, wb_data=0, pending=0, alu_hold=0, FIFO emptied, starve count=0; mem_ready=1 from first cycle after rst deasserts. In-flight data discarded.
- Mem accept: mem_valid && mem_ready at edge → push {mem_rd, mem_data}. mem_rd==0: handshake completes, nothing pushed.
- Arbitration per cycle, in priority order:
  - alu_hold=1 → FIFO head selected (FIFO guaranteed non-empty); any alu_valid is a protocol violation and is dropped.
  - alu_valid && alu_rd!=0 → ALU selected.
  - FIFO non-empty → head selected, popped at edge.
  - else none.
- alu_valid with alu_rd==0 → no write, not treated as selected; FIFO head may pop same cycle.
- Selected entry registered at edge: ranwi=1, write_reg/wb_data = entry; no selection → ranwi=0, write_reg/wb_data hold.
- Push and pop on same edge allowed at any occupancy except push needs !full at the start of cycle (no full-bypass). Count = count + push − pop.
- Starvation: count increments each cycle FIFO non-empty and head not popped; clears on pop or when empty. alu_hold = (count == STARVE_LIMIT), so hold lasts exactly one cycle and the head pops that cycle.
- Scoreboard: claim_en && claim_rd!=0 sets pending[claim_rd] at edge. pending[write_reg] cleared at the edge ending a cycle with ranwi=1 (register file written on the same edge). Same-edge set and clear of same bit → set wins. Claim of r0 ignored.

## Timing
- ALU: alu_valid at cycle N → ranwi=1 in cycle N+1; register file updated at end of N+1; pending bit low in N+2.
- Mem: accepted at edge ending cycle N → head in N+1 → ranwi=1 in N+2 at earliest.
- Max write throughput: one per cycle. mem_ready reflects occupancy after the previous edge; a pop in cycle N does not raise mem_ready until N+1.
- Worst-case FIFO head wait: STARVE_LIMIT cycles, then guaranteed write next cycle.

## Test plan
- Reset then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle → next cycle ranwi=1, write_reg=5, wb_data=0xDEADBEEF; following cycle ranwi=0.
- Claim r7, then mem result rd=7 data=0x12345678 with no ALU traffic → pending[7]=1 until the cycle after ranwi=1/write_reg=7, then 0.
- Three back-to-back mem results with DEPTH=2 while ALU busy every cycle → mem_ready=0 after two accepts; alu_hold=1 exactly at count 4; writes emerge in push order.
- alu_rd=0 and mem_rd=0 writes → ranwi never asserts for them; pending[0] stays 0; a queued mem entry pops in the alu_rd=0 cycle.
- Claim r9 on the same edge a write to r9 completes → pending[9]=1 afterwards.
- Assert rst mid-stream with FIFO holding 2 entries → immediately ranwi=0, pending=0, alu_hold=0; after release mem_ready=1 and no stale writes.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-side front end for the 32x32 register file: merges ALU and load results
// onto the single write port and tracks outstanding writes in a pending scoreboard.
module regfile_writeback #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        claim_en,
  input  logic [4:0]  claim_rd,
  output logic [31:0] pending,
  output logic        alu_hold,
  output logic [4:0]  write_reg,
  output logic [31:0] wb_data,
  output logic        ranwi
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [3:0]    HOLD_COUNT = 4'(STARVE_LIMIT);

  logic [4:0]    r_fifo_rd   [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_starve;
  logic [31:0]   r_pending;
  logic          r_ranwi;
  logic [4:0]    r_write_reg;
  logic [31:0]   r_wb_data;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_hold;
  logic          w_sel;
  logic [4:0]    w_sel_rd;
  logic [31:0]   w_sel_data;
  logic [31:0]   w_set_mask;
  logic [31:0]   w_clr_mask;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  // Writes to r0 complete the handshake but never occupy a FIFO slot.
  assign w_push  = mem_valid && !w_full && (mem_rd != 5'd0);
  assign w_hold  = (r_starve == HOLD_COUNT);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_sel      = 1'b0;
    w_pop      = 1'b0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    if (w_hold) begin
      w_sel      = !w_empty;
      w_pop      = !w_empty;
      w_sel_rd   = r_fifo_rd[r_rd_ptr];
      w_sel_data = r_fifo_data[r_rd_ptr];
    end else if (alu_valid && (alu_rd != 5'd0)) begin
      w_sel      = 1'b1;
      w_sel_rd   = alu_rd;
      w_sel_data = alu_data;
    end else if (!w_empty) begin
      w_sel      = 1'b1;
      w_pop      = 1'b1;
      w_sel_rd   = r_fifo_rd[r_rd_ptr];
      w_sel_data = r_fifo_data[r_rd_ptr];
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= mem_rd;
      r_fifo_data[r_wr_ptr] <= mem_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_empty || w_pop) r_starve <= '0;
      else                  r_starve <= r_starve + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ranwi     <= 1'b0;
      r_write_reg <= '0;
      r_wb_data   <= '0;
    end else begin
      r_ranwi <= w_sel;
      if (w_sel) begin
        r_write_reg <= w_sel_rd;
        r_wb_data   <= w_sel_data;
      end
    end
  end

  // A claim landing on the same edge as the write it shadows must survive, so set overrides clear.
  assign w_clr_mask = r_ranwi ? (32'd1 << r_write_reg) : 32'd0;
  assign w_set_mask = (claim_en && (claim_rd != 5'd0)) ? (32'd1 << claim_rd) : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;
  end

  assign mem_ready = !w_full;
  assign alu_hold  = w_hold;
  assign pending   = r_pending;
  assign write_reg = r_write_reg;
  assign wb_data   = r_wb_data;
  assign ranwi     = r_ranwi;

endmodule
